// File: rtl/serial_deser_rx.sv
// Serial frame receiver: start bit, WIDTH data bits, optional even-parity
// bit and a stop bit, one bit per ser_en strobe. A good word is presented
// on p_dout/p_valid and held until the downstream side takes it with p_ready.
//
// Handshake: a word transfers on any clk edge where p_valid=1 and p_ready=1.
// p_dout is stable while p_valid=1. A good frame finishing while a word is
// still held and not being taken is dropped and reported on overrun.
module serial_deser_rx #(
    parameter int WIDTH     = 4,
    parameter int LSB_FIRST = 1,
    parameter int PARITY_EN = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ser_din,
    input  logic             ser_en,
    input  logic             p_ready,
    output logic [WIDTH-1:0] p_dout,
    output logic             p_valid,
    output logic             busy,
    output logic             frame_err,
    output logic             parity_err,
    output logic             overrun,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2,
        STOP = 2'd3
    } state_t;

    localparam int            CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  shreg;
    logic              par_acc;   // running XOR of the data bits of this frame
    logic              mismatch;  // parity check result, held until the stop bit

    // Busy and debug state come straight from the state register.
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // Frame FSM, shift register, holding register and error pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            par_acc    <= 1'b0;
            mismatch   <= 1'b0;
            p_dout     <= '0;
            p_valid    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            // Error outputs are single-cycle pulses.
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;

            // Consumed word; a load in the STOP branch below overrides this.
            if (p_valid && p_ready) begin
                p_valid <= 1'b0;
            end

            if (ser_en) begin
                case (state)
                    IDLE: begin
                        // A high line is idle; a low bit is the start bit.
                        if (!ser_din) begin
                            state    <= DATA;
                            cnt      <= '0;
                            par_acc  <= 1'b0;
                            mismatch <= 1'b0;
                        end
                    end
                    DATA: begin
                        if (LSB_FIRST != 0) begin
                            shreg <= {ser_din, shreg[WIDTH-1:1]};
                        end else begin
                            shreg <= {shreg[WIDTH-2:0], ser_din};
                        end
                        par_acc <= par_acc ^ ser_din;
                        cnt     <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state <= (PARITY_EN != 0) ? PAR : STOP;
                        end
                    end
                    PAR: begin
                        // Even parity: data bits plus parity bit XOR to zero.
                        mismatch <= par_acc ^ ser_din;
                        state    <= STOP;
                    end
                    STOP: begin
                        // Always back to IDLE; a start bit needs its own strobe.
                        state <= IDLE;
                        if (!ser_din) begin
                            frame_err <= 1'b1;
                        end else if (mismatch) begin
                            parity_err <= 1'b1;
                        end else if (!p_valid || p_ready) begin
                            p_dout  <= shreg;
                            p_valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
